// File: rtl/ysyx_22050243_mem_pkg.sv
// Shared encodings and default widths for the IFU/LSU memory arbiter.
package ysyx_22050243_mem_pkg;

   localparam int ADDR_W_DEF  = 64;
   localparam int DATA_W_DEF  = 64;
   localparam int INST_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

endpackage

// File: rtl/ysyx_22050243_rr_arb2.sv
// Two-way round-robin selector between IFU and LSU with its last-grant register.
module ysyx_22050243_rr_arb2
   import ysyx_22050243_mem_pkg::*;
#(
   parameter bit LSU_FIRST = 1'b1
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   en,
   input  logic   req_ifu,
   input  logic   req_lsu,
   output logic   gnt_ifu,
   output logic   gnt_lsu,
   output owner_t sel
);

   owner_t last;

   always_comb begin
      sel = OWN_IFU;
      if (req_ifu && req_lsu)
         sel = (last == OWN_LSU) ? OWN_IFU : OWN_LSU;
      else if (req_lsu)
         sel = OWN_LSU;
   end

   assign gnt_ifu = en && req_ifu && (sel == OWN_IFU);
   assign gnt_lsu = en && req_lsu && (sel == OWN_LSU);

   // Seeding last with the loser makes the preferred side win the first conflict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last <= LSU_FIRST ? OWN_IFU : OWN_LSU;
      else if (gnt_ifu || gnt_lsu)
         last <= sel;
   end

endmodule

// File: rtl/ysyx_22050243_mem_arbiter.sv
// Shares one memory port between IFU fetches and LSU loads/stores, one access in flight.
// state | meaning
// IDLE  | waiting for a request, ready offered to the selected requester
// BUSY  | enables driven from latches, waiting for mem_done or watchdog expiry
// RESP  | owner's response held until resp_ready
module ysyx_22050243_mem_arbiter
   import ysyx_22050243_mem_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int INST_W    = INST_W_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF,
   parameter bit LSU_FIRST = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ifu_req_valid,
   output logic                ifu_req_ready,
   input  logic [ADDR_W-1:0]   ifu_addr,
   output logic                ifu_resp_valid,
   input  logic                ifu_resp_ready,
   output logic [INST_W-1:0]   ifu_rdata,
   output logic                ifu_err,
   input  logic                lsu_req_valid,
   output logic                lsu_req_ready,
   input  logic                lsu_we,
   input  logic [ADDR_W-1:0]   lsu_addr,
   input  logic [DATA_W-1:0]   lsu_wdata,
   input  logic [DATA_W/8-1:0] lsu_wmask,
   output logic                lsu_resp_valid,
   input  logic                lsu_resp_ready,
   output logic [DATA_W-1:0]   lsu_rdata,
   output logic                lsu_err,
   output logic                mem_r_en,
   output logic                mem_w_en,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_wmask,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_done
);

   // Down-counter loaded with TIMEOUT-1 so BUSY lasts at most TIMEOUT cycles.
   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   state_t              state, state_n;
   owner_t              owner, sel;
   logic                gnt_ifu, gnt_lsu, req_hs, resp_hs;
   logic                we_q, err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [DATA_W/8-1:0] wmask_q;
   logic [WD_W-1:0]     wd_cnt;

   ysyx_22050243_rr_arb2 #(.LSU_FIRST(LSU_FIRST)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (state == ST_IDLE),
      .req_ifu (ifu_req_valid),
      .req_lsu (lsu_req_valid),
      .gnt_ifu (gnt_ifu),
      .gnt_lsu (gnt_lsu),
      .sel     (sel)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n        = state;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      lsu_resp_valid = 1'b0;
      mem_r_en       = 1'b0;
      mem_w_en       = 1'b0;
      case (state)
         ST_IDLE: begin
            ifu_req_ready = gnt_ifu;
            lsu_req_ready = gnt_lsu;
            if (gnt_ifu || gnt_lsu)
               state_n = ST_BUSY;
         end
         ST_BUSY: begin
            mem_r_en = !we_q;
            mem_w_en = we_q;
            if (mem_done || (wd_cnt == '0))
               state_n = ST_RESP;
         end
         ST_RESP: begin
            ifu_resp_valid = (owner == OWN_IFU);
            lsu_resp_valid = (owner == OWN_LSU);
            if (resp_hs)
               state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign req_hs  = gnt_ifu || gnt_lsu;
   assign resp_hs = (state == ST_RESP) &&
                    (((owner == OWN_IFU) && ifu_resp_ready) ||
                     ((owner == OWN_LSU) && lsu_resp_ready));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner   <= OWN_IFU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         wd_cnt  <= '0;
      end else if (req_hs) begin
         owner   <= sel;
         we_q    <= (sel == OWN_LSU) && lsu_we;
         addr_q  <= (sel == OWN_LSU) ? lsu_addr : ifu_addr;
         wdata_q <= (sel == OWN_LSU) ? lsu_wdata : '0;
         wmask_q <= (sel == OWN_LSU) ? lsu_wmask : '0;
         wd_cnt  <= WD_W'(TIMEOUT - 1);
      end else if (state == ST_BUSY) begin
         if (mem_done) begin
            rdata_q <= we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
         end else if (wd_cnt == '0) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end else begin
            wd_cnt  <= wd_cnt - 1'b1;
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign lsu_rdata = rdata_q;
   assign lsu_err   = lsu_resp_valid && err_q;
   assign ifu_err   = ifu_resp_valid && err_q;
   assign ifu_rdata = addr_q[2] ? rdata_q[2*INST_W-1 -: INST_W] : rdata_q[INST_W-1:0];

endmodule

// File: tb/tb_ysyx_22050243_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter with hand-computed expectations.
module tb_ysyx_22050243_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
   logic [63:0] ifu_addr;
   logic [31:0] ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_resp_ready, lsu_err;
   logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [7:0]  lsu_wmask;
   logic        mem_r_en, mem_w_en, mem_done;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ysyx_22050243_mem_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ifu_req_valid  (ifu_req_valid),
      .ifu_req_ready  (ifu_req_ready),
      .ifu_addr       (ifu_addr),
      .ifu_resp_valid (ifu_resp_valid),
      .ifu_resp_ready (ifu_resp_ready),
      .ifu_rdata      (ifu_rdata),
      .ifu_err        (ifu_err),
      .lsu_req_valid  (lsu_req_valid),
      .lsu_req_ready  (lsu_req_ready),
      .lsu_we         (lsu_we),
      .lsu_addr       (lsu_addr),
      .lsu_wdata      (lsu_wdata),
      .lsu_wmask      (lsu_wmask),
      .lsu_resp_valid (lsu_resp_valid),
      .lsu_resp_ready (lsu_resp_ready),
      .lsu_rdata      (lsu_rdata),
      .lsu_err        (lsu_err),
      .mem_r_en       (mem_r_en),
      .mem_w_en       (mem_w_en),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_wmask      (mem_wmask),
      .mem_rdata      (mem_rdata),
      .mem_done       (mem_done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      ifu_req_valid = 0; ifu_addr = '0; ifu_resp_ready = 1;
      lsu_req_valid = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
      lsu_resp_ready = 1; mem_rdata = '0; mem_done = 0;
      repeat (2) tick();

      // reset state
      chk("rst_ifu_req_ready", ifu_req_ready, 0);
      chk("rst_lsu_req_ready", lsu_req_ready, 0);
      chk("rst_ifu_resp_valid", ifu_resp_valid, 0);
      chk("rst_lsu_resp_valid", lsu_resp_valid, 0);
      chk("rst_mem_en", {mem_r_en, mem_w_en}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_lsu_rdata", lsu_rdata, 0);
      rst_n = 1'b1;
      tick();

      // 1: IFU fetch, upper word selected
      mem_done = 1; mem_rdata = 64'h1234_5678_DEAD_BEEF;
      ifu_req_valid = 1; ifu_addr = 64'h8000_0004;
      #1;
      chk("t1_ifu_req_ready", ifu_req_ready, 1);
      chk("t1_lsu_req_ready", lsu_req_ready, 0);
      tick();
      ifu_req_valid = 0;
      chk("t1_busy_r_en", mem_r_en, 1);
      chk("t1_busy_w_en", mem_w_en, 0);
      chk("t1_busy_addr", mem_addr, 64'h8000_0004);
      chk("t1_busy_resp_valid", ifu_resp_valid, 0);
      tick();
      chk("t1_resp_valid", ifu_resp_valid, 1);
      chk("t1_rdata", ifu_rdata, 32'h1234_5678);
      chk("t1_err", ifu_err, 0);
      chk("t1_resp_r_en", mem_r_en, 0);
      chk("t1_lsu_resp_valid", lsu_resp_valid, 0);
      tick();
      chk("t1_idle_resp_valid", ifu_resp_valid, 0);

      // 2: LSU store, write enable exactly one cycle, rdata forced 0
      lsu_req_valid = 1; lsu_we = 1; lsu_addr = 64'h8000_0010;
      lsu_wdata = 64'hAAAA_AAAA_AAAA_AAAA; lsu_wmask = 8'h0F;
      #1;
      chk("t2_lsu_req_ready", lsu_req_ready, 1);
      tick();
      lsu_req_valid = 0;
      chk("t2_w_en", mem_w_en, 1);
      chk("t2_r_en", mem_r_en, 0);
      chk("t2_addr", mem_addr, 64'h8000_0010);
      chk("t2_wdata", mem_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
      chk("t2_wmask", mem_wmask, 8'h0F);
      tick();
      chk("t2_w_en_drop", mem_w_en, 0);
      chk("t2_resp_valid", lsu_resp_valid, 1);
      chk("t2_rdata", lsu_rdata, 0);
      chk("t2_err", lsu_err, 0);
      tick();
      lsu_we = 0;
      chk("t2_idle_w_en", mem_w_en, 0);

      // 3: fresh reset, persistent conflict alternates starting with LSU
      rst_n = 0; #1; rst_n = 1;
      ifu_req_valid = 1; ifu_addr = 64'h8000_0000;
      lsu_req_valid = 1; lsu_addr = 64'h8000_0100;
      for (int i = 0; i < 4; i++) begin
         logic exp_lsu;
         exp_lsu = (i % 2 == 0);
         #1;
         chk($sformatf("t3_lsu_ready_%0d", i), lsu_req_ready, exp_lsu);
         chk($sformatf("t3_ifu_ready_%0d", i), ifu_req_ready, !exp_lsu);
         tick();
         tick();
         chk($sformatf("t3_lsu_resp_%0d", i), lsu_resp_valid, exp_lsu);
         chk($sformatf("t3_ifu_resp_%0d", i), ifu_resp_valid, !exp_lsu);
         tick();
      end
      ifu_req_valid = 0; lsu_req_valid = 0;
      tick();

      // 4: watchdog, BUSY lasts 255 cycles then error response
      mem_done = 0; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      ifu_req_valid = 1; ifu_addr = 64'h8000_0004;
      tick();
      ifu_req_valid = 0;
      repeat (254) tick();
      chk("t4_last_busy_resp", ifu_resp_valid, 0);
      chk("t4_last_busy_r_en", mem_r_en, 1);
      tick();
      chk("t4_resp_valid", ifu_resp_valid, 1);
      chk("t4_err", ifu_err, 1);
      chk("t4_rdata", ifu_rdata, 0);
      chk("t4_r_en_drop", mem_r_en, 0);
      mem_done = 1;
      tick();
      chk("t4_idle", ifu_resp_valid, 0);

      // 5: response backpressure, data stable, other requester blocked
      lsu_resp_ready = 0; mem_rdata = 64'hCAFE_F00D_0BAD_F00D;
      lsu_req_valid = 1; lsu_we = 0; lsu_addr = 64'h8000_0020;
      tick();
      lsu_req_valid = 0;
      ifu_req_valid = 1; ifu_addr = 64'h8000_0008;
      tick();
      mem_rdata = 64'h1111_2222_3333_4444;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t5_resp_valid_%0d", i), lsu_resp_valid, 1);
         chk($sformatf("t5_rdata_%0d", i), lsu_rdata, 64'hCAFE_F00D_0BAD_F00D);
         chk($sformatf("t5_ifu_ready_%0d", i), ifu_req_ready, 0);
         tick();
      end
      lsu_resp_ready = 1;
      tick();
      chk("t5_lsu_resp_done", lsu_resp_valid, 0);
      chk("t5_ifu_ready_after", ifu_req_ready, 1);
      tick();
      ifu_req_valid = 0;
      tick();
      chk("t5_ifu_resp_valid", ifu_resp_valid, 1);
      chk("t5_ifu_rdata", ifu_rdata, 32'h3333_4444);
      tick();

      // 6: reset during a stalled store
      mem_done = 0;
      lsu_req_valid = 1; lsu_we = 1; lsu_addr = 64'h8000_0040;
      lsu_wdata = 64'h5555_5555_5555_5555; lsu_wmask = 8'hFF;
      tick();
      lsu_req_valid = 0;
      chk("t6_w_en_before", mem_w_en, 1);
      #1; rst_n = 0; #1;
      chk("t6_rst_w_en", mem_w_en, 0);
      chk("t6_rst_r_en", mem_r_en, 0);
      chk("t6_rst_addr", mem_addr, 0);
      chk("t6_rst_wdata", mem_wdata, 0);
      chk("t6_rst_wmask", mem_wmask, 0);
      chk("t6_rst_resp", lsu_resp_valid, 0);
      tick();
      rst_n = 1; lsu_we = 0;
      mem_done = 1; mem_rdata = 64'h0BAD_C0DE_0000_0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t6_no_w_en_%0d", i), mem_w_en, 0);
         chk($sformatf("t6_no_resp_%0d", i), lsu_resp_valid, 0);
      end
      ifu_req_valid = 1; ifu_addr = 64'h8000_0004;
      #1;
      chk("t6_ifu_ready", ifu_req_ready, 1);
      tick();
      ifu_req_valid = 0;
      chk("t6_ifu_r_en", mem_r_en, 1);
      tick();
      chk("t6_ifu_resp_valid", ifu_resp_valid, 1);
      chk("t6_ifu_rdata", ifu_rdata, 32'h0BAD_C0DE);
      chk("t6_ifu_err", ifu_err, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
